// File: rtl/zynq_axil_master_arb.sv
// rtl/zynq_axil_master_arb.sv - two-requester AXI4-Lite master with round-robin arbitration
// Option macro: ZYNQ_AXIL_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties).
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   req_v_i/req_w_i        per-requester valid and write flag
//   req_addr_i/data/mask   packed per-requester address, write data, byte strobes
//   req_ready_o            per-requester grant (combinational, IDLE only)
//   resp_v_o/resp_err_o    per-requester response valid and error
//   resp_data_o            shared read data (0 for writes)
//   resp_ready_i           per-requester response consume
//   m_axil_*               AXI4-Lite master AW, W, B, AR, R channels
module zynq_axil_master_arb #(
   parameter int addr_width_p = 32,
   parameter int data_width_p = 32
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [1:0]                    req_v_i,
   input  logic [1:0]                    req_w_i,
   input  logic [2*addr_width_p-1:0]     req_addr_i,
   input  logic [2*data_width_p-1:0]     req_data_i,
   input  logic [2*data_width_p/8-1:0]   req_mask_i,
   output logic [1:0]                    req_ready_o,
   output logic [1:0]                    resp_v_o,
   output logic [1:0]                    resp_err_o,
   output logic [data_width_p-1:0]       resp_data_o,
   input  logic [1:0]                    resp_ready_i,
   output logic [addr_width_p-1:0]       m_axil_awaddr,
   output logic [2:0]                    m_axil_awprot,
   output logic                          m_axil_awvalid,
   input  logic                          m_axil_awready,
   output logic [data_width_p-1:0]       m_axil_wdata,
   output logic [data_width_p/8-1:0]     m_axil_wstrb,
   output logic                          m_axil_wvalid,
   input  logic                          m_axil_wready,
   input  logic [1:0]                    m_axil_bresp,
   input  logic                          m_axil_bvalid,
   output logic                          m_axil_bready,
   output logic [addr_width_p-1:0]       m_axil_araddr,
   output logic [2:0]                    m_axil_arprot,
   output logic                          m_axil_arvalid,
   input  logic                          m_axil_arready,
   input  logic [data_width_p-1:0]       m_axil_rdata,
   input  logic [1:0]                    m_axil_rresp,
   input  logic                          m_axil_rvalid,
   output logic                          m_axil_rready
);
   localparam int strb_width_lp = data_width_p / 8;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;

   state_e                    state_q, state_d;
   logic                      gnt_sel;
   logic                      gnt_fire;
   logic                      grant_q;
   logic [addr_width_p-1:0]   addr_q;
   logic [data_width_p-1:0]   wdata_q;
   logic [strb_width_lp-1:0]  strb_q;
   logic                      awvalid_q, wvalid_q, arvalid_q;
   logic [data_width_p-1:0]   rdata_q;
   logic [1:0]                err_q;
   logic [1:0]                grant_oh;
   logic                      resp_fire;

`ifdef ZYNQ_AXIL_ARB_FIXED_PRIO_EN
   assign gnt_sel = ~req_v_i[0];
`else
   logic last_q;
   // On a tie the requester not served last wins; otherwise whichever is valid.
   assign gnt_sel = (&req_v_i) ? ~last_q : ~req_v_i[0];
`endif

   // Gating with aresetn keeps the grant from appearing while reset is held.
   assign gnt_fire  = (state_q == IDLE) && aresetn && (|req_v_i);
   assign grant_oh  = grant_q ? 2'b10 : 2'b01;
   assign resp_fire = (state_q == DONE) && resp_ready_i[grant_q];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      req_ready_o   = 2'b00;
      resp_v_o      = 2'b00;
      m_axil_bready = 1'b0;
      m_axil_rready = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_fire) begin
               req_ready_o = gnt_sel ? 2'b10 : 2'b01;
               state_d     = req_w_i[gnt_sel] ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            // A channel counts as done if it already handshook or handshakes now.
            if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
               state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            m_axil_bready = 1'b1;
            if (m_axil_bvalid) state_d = DONE;
         end
         RD_REQ: begin
            if (m_axil_arready) state_d = RD_RESP;
         end
         RD_RESP: begin
            m_axil_rready = 1'b1;
            if (m_axil_rvalid) state_d = DONE;
         end
         DONE: begin
            resp_v_o = grant_oh;
            if (resp_ready_i[grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         grant_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 2'b00;
      end else begin
         if (gnt_fire) begin
            grant_q   <= gnt_sel;
            addr_q    <= gnt_sel ? req_addr_i[2*addr_width_p-1:addr_width_p]
                                 : req_addr_i[addr_width_p-1:0];
            wdata_q   <= gnt_sel ? req_data_i[2*data_width_p-1:data_width_p]
                                 : req_data_i[data_width_p-1:0];
            strb_q    <= gnt_sel ? req_mask_i[2*strb_width_lp-1:strb_width_lp]
                                 : req_mask_i[strb_width_lp-1:0];
            awvalid_q <= req_w_i[gnt_sel];
            wvalid_q  <= req_w_i[gnt_sel];
            arvalid_q <= !req_w_i[gnt_sel];
         end else begin
            if (awvalid_q && m_axil_awready) awvalid_q <= 1'b0;
            if (wvalid_q && m_axil_wready)   wvalid_q  <= 1'b0;
            if (arvalid_q && m_axil_arready) arvalid_q <= 1'b0;
         end
         if (state_q == WR_RESP && m_axil_bvalid) begin
            rdata_q <= '0;
            err_q   <= grant_oh & {2{m_axil_bresp != 2'b00}};
         end
         if (state_q == RD_RESP && m_axil_rvalid) begin
            rdata_q <= m_axil_rdata;
            err_q   <= grant_oh & {2{m_axil_rresp != 2'b00}};
         end
      end
   end

`ifndef ZYNQ_AXIL_ARB_FIXED_PRIO_EN
   // Reset to requester 1 so requester 0 wins the first tie.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         last_q <= 1'b1;
      end else if (resp_fire) begin
         last_q <= grant_q;
      end
   end
`endif

   assign resp_data_o    = rdata_q;
   assign resp_err_o     = err_q;
   assign m_axil_awaddr  = addr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = strb_q;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_arvalid = arvalid_q;
endmodule

// File: tb/tb_zynq_axil_master_arb.sv
// tb/tb_zynq_axil_master_arb.sv - self-checking bench for zynq_axil_master_arb
module tb_zynq_axil_master_arb;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic [1:0]  req_v = '0, req_w = '0;
   logic [63:0] req_addr = '0, req_data = '0;
   logic [7:0]  req_mask = '0;
   logic [1:0]  req_ready_o, resp_v_o, resp_err_o;
   logic [31:0] resp_data_o;
   logic [1:0]  resp_ready = '0;
   logic [31:0] awaddr, wdata, araddr;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, arvalid, bready, rready;
   logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
   logic [1:0]  bresp = '0, rresp = '0;
   logic [31:0] rdata = '0;

   zynq_axil_master_arb dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_v_i(req_v), .req_w_i(req_w), .req_addr_i(req_addr),
      .req_data_i(req_data), .req_mask_i(req_mask), .req_ready_o(req_ready_o),
      .resp_v_o(resp_v_o), .resp_err_o(resp_err_o), .resp_data_o(resp_data_o),
      .resp_ready_i(resp_ready),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
      .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
      .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
      .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
      .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
      .m_axil_rready(rready)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      logic        w;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      int          a_dly, w_dly, r_dly, c_dly;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   vec_t vec[7];
   int   n_cmp = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int id, input logic w, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask,
                               input int a_dly, input int w_dly, input int r_dly,
                               input int c_dly, input logic [31:0] rd, input logic [1:0] resp,
                               input logic [31:0] exp_data, input logic exp_err);
      vec_t v;
      v.id = id; v.w = w; v.addr = addr; v.data = data; v.mask = mask;
      v.a_dly = a_dly; v.w_dly = w_dly; v.r_dly = r_dly; v.c_dly = c_dly;
      v.rdata = rd; v.resp = resp; v.exp_data = exp_data; v.exp_err = exp_err;
      return v;
   endfunction

   // Entered at the negedge on which the grant was seen; acts as AXI slave and consumer.
   task automatic serve(input vec_t v, input bit drop_req, input int gcyc);
      int cnt, n;
      bit a_seen, w_seen, a_now, w_now;
      exp_t e;
      @(negedge aclk);
      chk("req_ready_busy", 32'(req_ready_o), 32'd0);
      if (drop_req) req_v[v.id] = 1'b0;
      cnt = 0; a_seen = 0; w_seen = 0;
      if (v.w) begin
         chk("awaddr", awaddr, v.addr);
         chk("wdata", wdata, v.data);
         chk("wstrb", 32'(wstrb), 32'(v.mask));
         while (!(a_seen && w_seen) && cnt < 50) begin
            chk(a_seen ? "awvalid_drop" : "awvalid_hold", 32'(awvalid), a_seen ? 32'd0 : 32'd1);
            chk(w_seen ? "wvalid_drop" : "wvalid_hold", 32'(wvalid), w_seen ? 32'd0 : 32'd1);
            awready = !a_seen && cnt >= v.a_dly;
            wready  = !w_seen && cnt >= v.w_dly;
            a_now = awready && awvalid;
            w_now = wready && wvalid;
            @(posedge aclk);
            a_seen |= a_now; w_seen |= w_now;
            @(negedge aclk);
            awready = 0; wready = 0; cnt++;
         end
         chk("aw_w_done", 32'(a_seen && w_seen), 32'd1);
         for (int k = 0; k < v.r_dly; k++) @(negedge aclk);
         chk("bready", 32'(bready), 32'd1);
         bvalid = 1; bresp = v.resp;
         @(posedge aclk);
         @(negedge aclk);
         bvalid = 0; bresp = 2'b00;
      end else begin
         while (!a_seen && cnt < 50) begin
            chk("arvalid_hold", 32'(arvalid), 32'd1);
            chk("araddr", araddr, v.addr);
            arready = cnt >= v.a_dly;
            a_now = arready && arvalid;
            @(posedge aclk);
            a_seen = a_now;
            @(negedge aclk);
            arready = 0; cnt++;
         end
         chk("arvalid_drop", 32'(arvalid), 32'd0);
         for (int k = 0; k < v.r_dly; k++) @(negedge aclk);
         chk("rready", 32'(rready), 32'd1);
         rvalid = 1; rdata = v.rdata; rresp = v.resp;
         @(posedge aclk);
         @(negedge aclk);
         rvalid = 0; rresp = 2'b00; rdata = '0;
      end
      n = 0;
      while (resp_v_o == 2'b00 && n < 20) begin
         @(negedge aclk);
         n++;
      end
      e = sb.pop_front();
      if (resp_v_o == 2'b00) begin
         chk("resp_timeout", 32'd0, 32'd1);
         return;
      end
      if (v.a_dly == 0 && v.w_dly == 0 && v.r_dly == 0) chk("latency", cyc - gcyc, 32'd3);
      chk("resp_v", 32'(resp_v_o), 32'(1 << e.id));
      chk("resp_data", resp_data_o, e.data);
      chk("resp_err", 32'(resp_err_o), e.err ? 32'(1 << e.id) : 32'd0);
      for (int k = 0; k < v.c_dly; k++) begin
         @(negedge aclk);
         chk("resp_v_held", 32'(resp_v_o), 32'(1 << e.id));
         chk("resp_data_held", resp_data_o, e.data);
         chk("resp_err_held", 32'(resp_err_o), e.err ? 32'(1 << e.id) : 32'd0);
      end
      resp_ready[e.id] = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      resp_ready = '0;
      chk("resp_v_clear", 32'(resp_v_o), 32'd0);
   endtask

   task automatic run_txn(input vec_t v);
      int n, gcyc;
      req_v[v.id] = 1'b1;
      req_w[v.id] = v.w;
      req_addr[v.id*32 +: 32] = v.addr;
      req_data[v.id*32 +: 32] = v.data;
      req_mask[v.id*4 +: 4]   = v.mask;
      sb.push_back('{v.id, v.exp_data, v.exp_err});
      #1;
      n = 0;
      while (!req_ready_o[v.id] && n < 20) begin
         @(negedge aclk);
         #1;
         n++;
      end
      if (!req_ready_o[v.id]) begin
         chk("grant_timeout", 32'd0, 32'd1);
         void'(sb.pop_front());
         req_v = '0;
         return;
      end
      chk("grant_onehot", 32'(req_ready_o), 32'(1 << v.id));
      gcyc = cyc;
      serve(v, 1'b1, gcyc);
   endtask

   initial begin
      vec_t v;
      int n, expw;
      vec[0] = mk(0, 0, 32'h1000, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 0);
      vec[1] = mk(1, 1, 32'h20, 32'h12345678, 4'b0011, 0, 2, 0, 0, 0, 2'b00, 0, 0);
      vec[2] = mk(0, 1, 32'h40, 32'hFFFF0000, 4'b1100, 0, 0, 0, 5, 0, 2'b10, 0, 1);
      vec[3] = mk(1, 1, 32'h80, 32'hAABBCCDD, 4'b1111, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      vec[4] = mk(1, 0, 32'h84, 0, 0, 2, 0, 3, 1, 32'hCAFEF00D, 2'b11, 32'hCAFEF00D, 1);
      vec[5] = mk(0, 1, 32'h88, 32'h00000001, 4'b1111, 3, 0, 1, 0, 0, 2'b00, 0, 0);
      vec[6] = mk(0, 0, 32'h90, 0, 0, 0, 0, 0, 2, 32'h13579BDF, 2'b00, 32'h13579BDF, 0);

      // Reset state, with a request pending to show no grant during reset.
      aresetn = 1'b0;
      req_v = 2'b01;
      #12;
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      chk("rst_resp_v", 32'(resp_v_o), 32'd0);
      chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 32'd0);
      chk("rst_resp_data", resp_data_o, 32'd0);
      chk("rst_prot", {awprot, arprot}, 32'd0);
      @(negedge aclk);
      req_v = '0;
      aresetn = 1'b1;
      @(negedge aclk);

      // Both requesters continuously valid for four reads.
      req_v = 2'b11; req_w = 2'b00;
      req_addr = {32'h200, 32'h100};
      for (int k = 0; k < 4; k++) begin
         #1;
         n = 0;
         while (req_ready_o == 2'b00 && n < 20) begin
            @(negedge aclk);
            #1;
            n++;
         end
`ifdef ZYNQ_AXIL_ARB_FIXED_PRIO_EN
         expw = 0;
`else
         expw = k % 2;
`endif
         chk("arb_grant", 32'(req_ready_o), 32'(1 << expw));
         v = mk(expw, 0, expw ? 32'h200 : 32'h100, 0, 0, 0, 0, 0, 0,
                32'hA0000000 + k, 2'b00, 32'hA0000000 + k, 0);
         sb.push_back('{expw, v.exp_data, 1'b0});
         serve(v, 1'b0, cyc);
      end
      req_v = '0;
      @(negedge aclk);

      for (int i = 0; i < 7; i++) begin
         run_txn(vec[i]);
         @(negedge aclk);
      end

      // Reset while waiting for read data.
      req_v[0] = 1'b1; req_w[0] = 1'b0; req_addr[31:0] = 32'h3000;
      @(negedge aclk);
      req_v = '0;
      chk("rst_seq_arvalid", 32'(arvalid), 32'd1);
      arready = 1;
      @(posedge aclk);
      @(negedge aclk);
      arready = 0;
      chk("rst_seq_rready", 32'(rready), 32'd1);
      aresetn = 1'b0;
      #1;
      chk("midrst_arvalid", 32'(arvalid), 32'd0);
      chk("midrst_rready", 32'(rready), 32'd0);
      chk("midrst_resp_v", 32'(resp_v_o), 32'd0);
      chk("midrst_resp_data", resp_data_o, 32'd0);
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      sb.delete();
      run_txn(mk(0, 0, 32'h44, 0, 0, 0, 0, 0, 0, 32'h5A5A1234, 2'b00, 32'h5A5A1234, 0));
      @(negedge aclk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
